cpu_bus_arbiter: RTL and testbench
==================================

CPU_BUS_ARBITER -- requirements
Module: cpu_bus_arbiter

Interface
REQ-001 SHALL have parameter DATA_BURST_MAX, default 2, the number of consecutive data grants allowed while an instruction request waits.
REQ-002 SHALL have ports, in order:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
REQ-003 SHALL have instruction-side ports:
- cpui_request  in  1  one-cycle request pulse.
- cpui_addr  in  32  instruction address.
- cpui_rdata  out  32  returned instruction.
- cpui_ack  out  1  one-cycle completion pulse.
REQ-004 SHALL have data-side ports:
- cpud_request  in  1  one-cycle request pulse.
- cpud_addr  in  32  data address.
- cpud_write  in  1  1 = write.
- cpud_byte_enable  in  4  write byte lanes.
- cpud_wdata  in  32  write data.
- cpud_rdata  out  32  read data.
- cpud_ack  out  1  one-cycle completion pulse.
REQ-005 SHALL have memory-side ports:
- mem_request  out  1  one-cycle request pulse.
- mem_addr  out  32  address.
- mem_write  out  1  write flag.
- mem_byte_enable  out  4  byte lanes.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data.
- mem_ack  in  1  completion pulse.
REQ-006 SHALL have overrun out 1, a one-cycle pulse when a request arrives on a port whose previous request is still pending or in flight.

Function
REQ-007 SHALL hold one pending slot per port, capturing the address, write flag, byte enables and wdata on the request pulse.
REQ-008 SHALL leave the pending slot unchanged when a new request arrives while that port's slot is pending or in flight, and SHALL pulse overrun in that case.
REQ-009 SHALL use FSM states IDLE, BUSY_I and BUSY_D; only one memory transaction SHALL be in flight at a time.
REQ-010 In IDLE with at least one slot pending, SHALL assert mem_request for exactly one cycle, drive that slot's fields on mem_*, and enter BUSY_I or BUSY_D.
REQ-011 A request arriving while IDLE with no slot pending SHALL produce mem_request on the next cycle (latency 1).
REQ-012 Instruction fetches SHALL drive mem_write = 0 and mem_byte_enable = 4'hF.
REQ-013 mem_addr, mem_write, mem_byte_enable and mem_wdata SHALL stay stable from mem_request until the cycle after mem_ack.
REQ-014 Arbitration when both slots are pending: data wins, unless the data-grant counter equals DATA_BURST_MAX, in which case instruction wins.
REQ-015 The data-grant counter SHALL increment on each data grant made while an instruction slot is pending, SHALL clear on any instruction grant, and SHALL saturate at DATA_BURST_MAX.
REQ-016 On mem_ack in BUSY_x, SHALL register mem_rdata into cpux_rdata, pulse cpux_ack for one cycle on the next cycle, clear slot x, and return to IDLE.
REQ-017 The earliest next mem_request SHALL be the cycle after mem_ack (back-to-back grant from IDLE).
REQ-018 cpux_rdata SHALL hold its value until the next ack on that port.
REQ-019 mem_ack while IDLE SHALL be ignored: no ack pulse, no state change.
REQ-020 When a request on port x coincides with the cycle mem_ack completes port x, SHALL capture the new request as pending, with no overrun.
REQ-021 Simultaneous cpui_request and cpud_request in IDLE SHALL both be captured, and arbitration SHALL follow REQ-014.

Reset
REQ-022 While reset = 0, SHALL force FSM = IDLE, both slots empty, counter = 0, and all outputs 0, including rdata.
REQ-023 Reset asserted mid-transaction SHALL abandon it; a mem_ack arriving after reset release SHALL be ignored per REQ-019.
REQ-024 Reset release SHALL take effect on the first rising clock edge after reset goes high.

Verification
REQ-025 SHALL cover:
- Single fetch: cpui_request, addr 0x100 at cycle 0; mem_ack, rdata 0xDEADBEEF at cycle 3 -> mem_request at cycle 1 with addr 0x100, cpui_ack and cpui_rdata 0xDEADBEEF at cycle 4.
- Simultaneous requests: I addr 0x10 and D write addr 0x20, wdata 0x55, be 4'h3 -> D issued first with mem_write 1, be 4'h3; I issued the cycle after the D mem_ack.
- Starvation: I pending while D requests 3 times back-to-back with DATA_BURST_MAX 2 -> grant order D, D, I, D.
- Overrun: second cpud_request before cpud_ack -> overrun pulse; the first transaction's address is unchanged on mem_addr.
- Reset mid-flight: reset low during BUSY_D, then a stray mem_ack after release -> no cpud_ack; all outputs 0.
- Coincident re-request: cpui_request on the same cycle as mem_ack for I -> new mem_request the following cycle, no overrun.

Source files
------------

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter
// ---------------
// Shares one memory port between an instruction-fetch client (cpui_*) and a
// data client (cpud_*). Each client owns a single pending slot that captures
// its request fields on the request pulse. Only one memory transaction is in
// flight at a time.
//
// Arbitration when both slots are pending:
//   - data wins by default,
//   - unless DATA_BURST_MAX data grants have already been made while the
//     instruction slot was waiting, in which case instruction wins.
//
// Handshake (all pulses last exactly one cycle):
//   cpux_request -> the slot captures the fields if the slot is free, or if it
//   is being completed in the same cycle. Otherwise the request is dropped and
//   overrun pulses.
//   mem_request  -> asserted in the grant cycle. mem_addr, mem_write,
//   mem_byte_enable and mem_wdata hold from that cycle until the next grant.
//   mem_ack      -> accepted only in BUSY_I or BUSY_D. mem_rdata is registered
//   into cpux_rdata, and cpux_ack pulses on the following cycle.
//
// Ports:
//   clock, reset              clock (rising edge) and async active-low reset
//   cpui_request/addr         instruction request pulse and address
//   cpui_rdata/ack            fetched instruction and completion pulse
//   cpud_request/addr/write/
//   cpud_byte_enable/wdata    data request pulse and its fields
//   cpud_rdata/ack            read data and completion pulse
//   mem_request/addr/write/
//   mem_byte_enable/wdata     memory request pulse and its held fields
//   mem_rdata/ack             memory read data and completion pulse
//   overrun                   request dropped because that port's slot was busy
//   fsm_state                 debug view of the arbiter state
//                             (0 = IDLE, 1 = BUSY_I, 2 = BUSY_D)

module cpu_bus_arbiter #(
    parameter int DATA_BURST_MAX = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpui_request,
    input  logic [31:0] cpui_addr,
    output logic [31:0] cpui_rdata,
    output logic        cpui_ack,
    input  logic        cpud_request,
    input  logic [31:0] cpud_addr,
    input  logic        cpud_write,
    input  logic [3:0]  cpud_byte_enable,
    input  logic [31:0] cpud_wdata,
    output logic [31:0] cpud_rdata,
    output logic        cpud_ack,
    output logic        mem_request,
    output logic [31:0] mem_addr,
    output logic        mem_write,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        overrun,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam int CNT_W = (DATA_BURST_MAX < 1) ? 1 : $clog2(DATA_BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_BURST_MAX);

    state_t state, next_state;

    // pending slots
    logic        pend_i;
    logic [31:0] addr_i;
    logic        pend_d;
    logic [31:0] addr_d;
    logic        write_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;

    // fields of the transaction most recently granted
    logic [31:0] hold_addr;
    logic        hold_write;
    logic [3:0]  hold_be;
    logic [31:0] hold_wdata;

    logic [CNT_W-1:0] data_cnt;

    logic grant_i, grant_d, done_i, done_d;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and grant/completion decode
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        done_i     = 1'b0;
        done_d     = 1'b0;
        case (state)
            IDLE: begin
                // Data wins unless the waiting fetch has used up its patience.
                if (pend_d && (!pend_i || (data_cnt != CNT_MAX))) begin
                    grant_d    = 1'b1;
                    next_state = BUSY_D;
                end else if (pend_i) begin
                    grant_i    = 1'b1;
                    next_state = BUSY_I;
                end
            end
            BUSY_I: begin
                if (mem_ack) begin
                    done_i     = 1'b1;
                    next_state = IDLE;
                end
            end
            BUSY_D: begin
                if (mem_ack) begin
                    done_d     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Memory-side outputs: the selected slot in the grant cycle, otherwise
    // the fields held from the last grant.
    // ------------------------------------------------------------------
    always_comb begin
        mem_request     = grant_i | grant_d;
        mem_addr        = hold_addr;
        mem_write       = hold_write;
        mem_byte_enable = hold_be;
        mem_wdata       = hold_wdata;
        if (grant_d) begin
            mem_addr        = addr_d;
            mem_write       = write_d;
            mem_byte_enable = be_d;
            mem_wdata       = wdata_d;
        end else if (grant_i) begin
            mem_addr        = addr_i;
            mem_write       = 1'b0;
            mem_byte_enable = 4'hF;
            mem_wdata       = 32'h0;
        end
    end

    // A slot being completed this cycle counts as free, so a coincident
    // re-request is captured and does not overrun.
    assign overrun = (cpui_request && pend_i && !done_i) ||
                     (cpud_request && pend_d && !done_d);

    assign fsm_state = state;

    // ------------------------------------------------------------------
    // Pending slots
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_i  <= 1'b0;
            addr_i  <= 32'h0;
            pend_d  <= 1'b0;
            addr_d  <= 32'h0;
            write_d <= 1'b0;
            be_d    <= 4'h0;
            wdata_d <= 32'h0;
        end else begin
            if (cpui_request && (!pend_i || done_i)) begin
                pend_i <= 1'b1;
                addr_i <= cpui_addr;
            end else if (done_i) begin
                pend_i <= 1'b0;
            end

            if (cpud_request && (!pend_d || done_d)) begin
                pend_d  <= 1'b1;
                addr_d  <= cpud_addr;
                write_d <= cpud_write;
                be_d    <= cpud_byte_enable;
                wdata_d <= cpud_wdata;
            end else if (done_d) begin
                pend_d <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Held memory fields and data-grant counter
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_addr  <= 32'h0;
            hold_write <= 1'b0;
            hold_be    <= 4'h0;
            hold_wdata <= 32'h0;
            data_cnt   <= '0;
        end else begin
            if (grant_d) begin
                hold_addr  <= addr_d;
                hold_write <= write_d;
                hold_be    <= be_d;
                hold_wdata <= wdata_d;
            end else if (grant_i) begin
                hold_addr  <= addr_i;
                hold_write <= 1'b0;
                hold_be    <= 4'hF;
                hold_wdata <= 32'h0;
            end

            if (grant_i) begin
                data_cnt <= '0;
            end else if (grant_d && pend_i && (data_cnt != CNT_MAX)) begin
                data_cnt <= data_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Client responses
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cpui_ack   <= 1'b0;
            cpui_rdata <= 32'h0;
            cpud_ack   <= 1'b0;
            cpud_rdata <= 32'h0;
        end else begin
            cpui_ack <= done_i;
            cpud_ack <= done_d;
            if (done_i) begin
                cpui_rdata <= mem_rdata;
            end
            if (done_d) begin
                cpud_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter. Inputs change 1 ns after the rising
// edge, and outputs are checked on the falling edge. "Cycle N" is the period
// that starts at rising edge N.

module tb_cpu_bus_arbiter;

    logic        clock;
    logic        reset;
    logic        cpui_request;
    logic [31:0] cpui_addr;
    logic [31:0] cpui_rdata;
    logic        cpui_ack;
    logic        cpud_request;
    logic [31:0] cpud_addr;
    logic        cpud_write;
    logic [3:0]  cpud_byte_enable;
    logic [31:0] cpud_wdata;
    logic [31:0] cpud_rdata;
    logic        cpud_ack;
    logic        mem_request;
    logic [31:0] mem_addr;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        overrun;
    logic [1:0]  fsm_state;

    int total = 0;
    int bad   = 0;

    cpu_bus_arbiter #(.DATA_BURST_MAX(2)) dut (
        .clock            (clock),
        .reset            (reset),
        .cpui_request     (cpui_request),
        .cpui_addr        (cpui_addr),
        .cpui_rdata       (cpui_rdata),
        .cpui_ack         (cpui_ack),
        .cpud_request     (cpud_request),
        .cpud_addr        (cpud_addr),
        .cpud_write       (cpud_write),
        .cpud_byte_enable (cpud_byte_enable),
        .cpud_wdata       (cpud_wdata),
        .cpud_rdata       (cpud_rdata),
        .cpud_ack         (cpud_ack),
        .mem_request      (mem_request),
        .mem_addr         (mem_addr),
        .mem_write        (mem_write),
        .mem_byte_enable  (mem_byte_enable),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .mem_ack          (mem_ack),
        .overrun          (overrun),
        .fsm_state        (fsm_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ------------------------------------------------------------------
    // helpers
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance to the next cycle and drop all one-cycle pulses
    task automatic tick();
        @(posedge clock);
        #1;
        cpui_request = 1'b0;
        cpud_request = 1'b0;
        mem_ack      = 1'b0;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic drive_i(input logic [31:0] addr);
        cpui_request = 1'b1;
        cpui_addr    = addr;
    endtask

    task automatic drive_d(input logic [31:0] addr, input logic wr,
                           input logic [3:0] be, input logic [31:0] wd);
        cpud_request     = 1'b1;
        cpud_addr        = addr;
        cpud_write       = wr;
        cpud_byte_enable = be;
        cpud_wdata       = wd;
    endtask

    task automatic drive_ack(input logic [31:0] rd);
        mem_ack   = 1'b1;
        mem_rdata = rd;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".mem_request"}, {31'h0, mem_request}, 32'h0);
        chk({tag, ".mem_addr"}, mem_addr, 32'h0);
        chk({tag, ".mem_write"}, {31'h0, mem_write}, 32'h0);
        chk({tag, ".mem_be"}, {28'h0, mem_byte_enable}, 32'h0);
        chk({tag, ".mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, ".cpui_ack"}, {31'h0, cpui_ack}, 32'h0);
        chk({tag, ".cpui_rdata"}, cpui_rdata, 32'h0);
        chk({tag, ".cpud_ack"}, {31'h0, cpud_ack}, 32'h0);
        chk({tag, ".cpud_rdata"}, cpud_rdata, 32'h0);
        chk({tag, ".overrun"}, {31'h0, overrun}, 32'h0);
        chk({tag, ".state"}, {30'h0, fsm_state}, 32'h0);
    endtask

    task automatic chk_grant(input string tag, input logic [31:0] addr,
                             input logic wr, input logic [3:0] be, input logic [31:0] wd);
        chk({tag, ".mem_request"}, {31'h0, mem_request}, 32'h1);
        chk({tag, ".mem_addr"}, mem_addr, addr);
        chk({tag, ".mem_write"}, {31'h0, mem_write}, {31'h0, wr});
        chk({tag, ".mem_be"}, {28'h0, mem_byte_enable}, {28'h0, be});
        chk({tag, ".mem_wdata"}, mem_wdata, wd);
    endtask

    // ------------------------------------------------------------------
    // directed sequence
    // ------------------------------------------------------------------
    initial begin
        reset            = 1'b0;
        cpui_request     = 1'b0;
        cpui_addr        = 32'h0;
        cpud_request     = 1'b0;
        cpud_addr        = 32'h0;
        cpud_write       = 1'b0;
        cpud_byte_enable = 4'h0;
        cpud_wdata       = 32'h0;
        mem_rdata        = 32'h0;
        mem_ack          = 1'b0;

        // reset state
        repeat (2) @(posedge clock);
        #1;
        mid();
        chk_all_zero("reset");
        tick();
        reset = 1'b1;
        tick();

        // stray mem_ack while idle is ignored
        drive_ack(32'h9999_9999);
        mid();
        chk("idle_ack.mem_request", {31'h0, mem_request}, 32'h0);
        tick();
        mid();
        chk("idle_ack.cpui_ack", {31'h0, cpui_ack}, 32'h0);
        chk("idle_ack.cpud_ack", {31'h0, cpud_ack}, 32'h0);
        chk("idle_ack.state", {30'h0, fsm_state}, 32'h0);
        tick();

        // single fetch
        drive_i(32'h100);                                   // cycle 0
        mid();
        chk("fetch.c0_req", {31'h0, mem_request}, 32'h0);
        tick();                                             // cycle 1
        mid();
        chk_grant("fetch.c1", 32'h100, 1'b0, 4'hF, 32'h0);
        tick();                                             // cycle 2
        mid();
        chk("fetch.c2_req", {31'h0, mem_request}, 32'h0);
        chk("fetch.c2_addr_hold", mem_addr, 32'h100);
        chk("fetch.c2_state", {30'h0, fsm_state}, 32'h1);
        tick();                                             // cycle 3
        drive_ack(32'hDEAD_BEEF);
        mid();
        chk("fetch.c3_ack", {31'h0, cpui_ack}, 32'h0);
        chk("fetch.c3_addr_hold", mem_addr, 32'h100);
        tick();                                             // cycle 4
        mid();
        chk("fetch.c4_ack", {31'h0, cpui_ack}, 32'h1);
        chk("fetch.c4_rdata", cpui_rdata, 32'hDEAD_BEEF);
        chk("fetch.c4_dack", {31'h0, cpud_ack}, 32'h0);
        tick();                                             // cycle 5
        mid();
        chk("fetch.c5_ack", {31'h0, cpui_ack}, 32'h0);
        chk("fetch.c5_rdata_hold", cpui_rdata, 32'hDEAD_BEEF);
        tick();

        // simultaneous requests: data first, fetch right after data ack
        drive_i(32'h10);
        drive_d(32'h20, 1'b1, 4'h3, 32'h55);
        mid();
        chk("simul.c0_overrun", {31'h0, overrun}, 32'h0);
        tick();
        mid();
        chk_grant("simul.d_grant", 32'h20, 1'b1, 4'h3, 32'h55);
        tick();
        drive_ack(32'h0);
        mid();
        chk("simul.busy_req", {31'h0, mem_request}, 32'h0);
        chk("simul.busy_state", {30'h0, fsm_state}, 32'h2);
        tick();
        mid();
        chk("simul.dack", {31'h0, cpud_ack}, 32'h1);
        chk_grant("simul.i_grant", 32'h10, 1'b0, 4'hF, 32'h0);
        tick();
        drive_ack(32'h1234);
        tick();
        mid();
        chk("simul.iack", {31'h0, cpui_ack}, 32'h1);
        chk("simul.irdata", cpui_rdata, 32'h1234);
        chk("simul.drdata_hold", cpud_rdata, 32'h0);
        tick();

        // starvation: grant order D, D, I, D with DATA_BURST_MAX = 2
        drive_i(32'h40);
        drive_d(32'hA0, 1'b0, 4'hF, 32'h0);
        tick();
        mid();
        chk_grant("starve.g1_d", 32'hA0, 1'b0, 4'hF, 32'h0);
        tick();
        drive_ack(32'hA0A0);
        drive_d(32'hA4, 1'b0, 4'hF, 32'h0);
        mid();
        chk("starve.rereq_overrun", {31'h0, overrun}, 32'h0);
        tick();
        mid();
        chk_grant("starve.g2_d", 32'hA4, 1'b0, 4'hF, 32'h0);
        chk("starve.dack1", cpud_rdata, 32'hA0A0);
        tick();
        drive_ack(32'hA4A4);
        drive_d(32'hA8, 1'b0, 4'hF, 32'h0);
        tick();
        mid();
        chk_grant("starve.g3_i", 32'h40, 1'b0, 4'hF, 32'h0);
        tick();
        drive_ack(32'h4040);
        tick();
        mid();
        chk("starve.iack", {31'h0, cpui_ack}, 32'h1);
        chk("starve.irdata", cpui_rdata, 32'h4040);
        chk_grant("starve.g4_d", 32'hA8, 1'b0, 4'hF, 32'h0);
        tick();
        drive_ack(32'hA8A8);
        tick();
        mid();
        chk("starve.dack3", {31'h0, cpud_ack}, 32'h1);
        chk("starve.drdata3", cpud_rdata, 32'hA8A8);
        tick();

        // overrun: second data request before the first is acked
        drive_d(32'h300, 1'b0, 4'hF, 32'h0);
        tick();
        drive_d(32'h304, 1'b1, 4'h1, 32'h77);
        mid();
        chk("ovr.pulse", {31'h0, overrun}, 32'h1);
        chk_grant("ovr.grant", 32'h300, 1'b0, 4'hF, 32'h0);
        tick();
        mid();
        chk("ovr.pulse_end", {31'h0, overrun}, 32'h0);
        chk("ovr.addr_kept", mem_addr, 32'h300);
        chk("ovr.write_kept", {31'h0, mem_write}, 32'h0);
        drive_ack(32'hCAFE);
        tick();
        mid();
        chk("ovr.dack", {31'h0, cpud_ack}, 32'h1);
        chk("ovr.drdata", cpud_rdata, 32'hCAFE);
        chk("ovr.no_reissue", {31'h0, mem_request}, 32'h0);
        tick();

        // coincident re-request on the instruction port
        drive_i(32'h500);
        tick();
        mid();
        chk_grant("coin.g1", 32'h500, 1'b0, 4'hF, 32'h0);
        tick();
        drive_ack(32'h11);
        drive_i(32'h504);
        mid();
        chk("coin.overrun", {31'h0, overrun}, 32'h0);
        tick();
        mid();
        chk("coin.iack", {31'h0, cpui_ack}, 32'h1);
        chk("coin.irdata", cpui_rdata, 32'h11);
        chk_grant("coin.g2", 32'h504, 1'b0, 4'hF, 32'h0);
        tick();
        drive_ack(32'h22);
        tick();
        mid();
        chk("coin.iack2", {31'h0, cpui_ack}, 32'h1);
        chk("coin.irdata2", cpui_rdata, 32'h22);
        tick();

        // reset mid-flight, then a stray mem_ack after release
        drive_d(32'h600, 1'b1, 4'hC, 32'h66);
        tick();
        mid();
        chk_grant("rst.grant", 32'h600, 1'b1, 4'hC, 32'h66);
        tick();
        mid();
        chk("rst.busy_d", {30'h0, fsm_state}, 32'h2);
        reset = 1'b0;
        #1;
        chk_all_zero("rst.async");
        tick();
        mid();
        chk_all_zero("rst.held");
        tick();
        reset = 1'b1;
        tick();
        drive_ack(32'hBAD0);
        mid();
        chk("rst.stray_req", {31'h0, mem_request}, 32'h0);
        tick();
        mid();
        chk_all_zero("rst.after_stray");
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // hard stop in case the sequence above never completes
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
